// File: rtl/terrain_crater_scheduler.sv
// Crater scheduler: grants one bomb request at a time (round-robin), then sweeps
// the crater's columns with read-clear-write cycles confined to vertical blanking.
module terrain_crater_scheduler #(
    parameter int N_REQ     = 2,
    parameter int TERRAIN_W = 640,
    parameter int TERRAIN_H = 512,
    parameter int R_BITS    = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*10-1:0]     req_x,
    input  logic [N_REQ*10-1:0]     req_y,
    input  logic [N_REQ*R_BITS-1:0] req_r,
    output logic [N_REQ-1:0]        ack,
    input  logic                    vblank,
    input  logic [9:0]              disp_addr,
    output logic [9:0]              mem_addr,
    input  logic [TERRAIN_H-1:0]    mem_rdata,
    output logic [TERRAIN_H-1:0]    mem_wdata,
    output logic                    mem_we,
    output logic                    busy,
    output logic                    done
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int RW = 2 * R_BITS + 1;

    typedef enum logic [2:0] {IDLE, CALC_INIT, CALC, RD, RDW, WR, NEXT} state_t;
    state_t state, state_next;

    logic [PW-1:0]        ptr, ptr_next;
    logic [9:0]           cx, cy;
    logic [R_BITS-1:0]    r, h;
    // One bit wider than the 11-bit column range so cx+r can never wrap.
    logic signed [11:0]   col;
    logic [RW-1:0]        rem;
    logic [TERRAIN_H-1:0] word;

    logic                 grant_valid;
    logic [N_REQ-1:0]     grant_vec;
    logic [9:0]           gx, gy;
    logic [R_BITS-1:0]    gr;

    logic signed [11:0]   cx_s, r_s, dx, lo_s, col_last;
    logic [R_BITS-1:0]    adx;
    logic [2*R_BITS-1:0]  dx_sq, r_sq;
    logic [R_BITS:0]      hp1;
    logic [2*R_BITS+1:0]  hp1_sq;
    logic [11:0]          lo, hi;
    logic                 grow, in_range, last_col, cy_ok;
    logic [TERRAIN_H-1:0] clr_mask;

    assign cx_s     = signed'({2'b00, cx});
    assign r_s      = signed'(12'(r));
    assign dx       = col - cx_s;
    assign adx      = R_BITS'(dx[11] ? -dx : dx);
    assign dx_sq    = adx * adx;
    assign r_sq     = r * r;
    assign hp1      = {1'b0, h} + 1'b1;
    assign hp1_sq   = hp1 * hp1;
    assign grow     = hp1_sq <= {1'b0, rem};
    assign in_range = !col[11] && (col < signed'(12'(TERRAIN_W)));
    assign col_last = cx_s + r_s;
    assign last_col = (col == col_last);
    assign cy_ok    = {2'b00, cy} < 12'(TERRAIN_H);
    assign lo_s     = signed'({2'b00, cy}) - signed'(12'(h));
    assign lo       = lo_s[11] ? 12'd0 : unsigned'(lo_s);
    assign hi       = {2'b00, cy} + 12'(h);

    // Rows cy-h..cy+h (clipped to the word) are cleared; a centre below the terrain clears nothing.
    always_comb begin
        clr_mask = '0;
        for (int b = 0; b < TERRAIN_H; b++) begin
            clr_mask[b] = cy_ok && (12'(b) >= lo) && (12'(b) <= hi);
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_vec   = '0;
        ptr_next    = ptr;
        gx          = '0;
        gy          = '0;
        gr          = '0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!grant_valid && req[i] && (i == (int'(ptr) + k) % N_REQ)) begin
                    grant_valid  = 1'b1;
                    grant_vec[i] = 1'b1;
                    gx           = req_x[i*10 +: 10];
                    gy           = req_y[i*10 +: 10];
                    gr           = req_r[i*R_BITS +: R_BITS];
                    ptr_next     = PW'((i + 1) % N_REQ);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr  <= '0;
            cx   <= '0;
            cy   <= '0;
            r    <= '0;
            h    <= '0;
            col  <= '0;
            rem  <= '0;
            word <= '0;
        end else begin
            case (state)
                IDLE: if (grant_valid) begin
                    cx  <= gx;
                    cy  <= gy;
                    r   <= gr;
                    col <= signed'({2'b00, gx}) - signed'(12'(gr));
                    ptr <= ptr_next;
                end
                CALC_INIT: begin
                    rem <= RW'(r_sq) - RW'(dx_sq);
                    h   <= '0;
                end
                CALC: if (grow) h <= h + 1'b1;
                RDW:  if (vblank) word <= mem_rdata;
                NEXT: if (!last_col) col <= col + 12'sd1;
                default: ;
            endcase
        end
    end

    // Losing vblank anywhere in the access drops back to RD, so the column is redone in full.
    always_comb begin
        state_next = state;
        ack        = '0;
        done       = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        mem_addr   = disp_addr;
        busy       = (state != IDLE);
        case (state)
            IDLE: if (grant_valid) begin
                ack        = reset_n ? grant_vec : '0;
                state_next = CALC_INIT;
            end
            CALC_INIT: state_next = in_range ? CALC : NEXT;
            CALC:      if (!grow) state_next = RD;
            RD: if (vblank) begin
                mem_addr   = col[9:0];
                state_next = RDW;
            end
            RDW: begin
                if (vblank) begin
                    mem_addr   = col[9:0];
                    state_next = WR;
                end else begin
                    state_next = RD;
                end
            end
            WR: begin
                if (vblank) begin
                    mem_addr   = col[9:0];
                    mem_we     = 1'b1;
                    mem_wdata  = word & ~clr_mask;
                    state_next = NEXT;
                end else begin
                    state_next = RD;
                end
            end
            NEXT: begin
                if (last_col) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = CALC_INIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_terrain_crater_scheduler.sv
// Bench for terrain_crater_scheduler: a behavioural terrain RAM plus a scoreboard
// of expected column writes, filled as each crater is granted.
module tb_terrain_crater_scheduler;
    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   req;
    logic [19:0]  req_x, req_y;
    logic [11:0]  req_r;
    logic [1:0]   ack;
    logic         vblank;
    logic [9:0]   disp_addr, mem_addr;
    logic [511:0] mem_rdata, mem_wdata;
    logic         mem_we, busy, done;

    typedef struct packed {
        logic [9:0]   addr;
        logic [511:0] data;
    } wr_t;

    wr_t          exp_q[$];
    wr_t          exp_w;
    logic [511:0] ram     [640];
    bit           wvalid  [640];
    logic [511:0] exp_ram [640];
    int           crx[2], cry[2], crr[2];
    int           total = 0;
    int           bad = 0;
    int           done_cnt = 0;

    terrain_crater_scheduler #(.N_REQ(2), .TERRAIN_W(640), .TERRAIN_H(512), .R_BITS(6)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_x(req_x), .req_y(req_y),
        .req_r(req_r), .ack(ack), .vblank(vblank), .disp_addr(disp_addr),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Terrain RAM: unwritten columns read as solid ground (all ones).
    always @(posedge clk) begin
        if (mem_addr < 10'd640) mem_rdata <= wvalid[mem_addr] ? ram[mem_addr] : '1;
        else                    mem_rdata <= '0;
        if (mem_we && mem_addr < 10'd640) begin
            ram[mem_addr]    <= mem_wdata;
            wvalid[mem_addr] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL write_unexpected got addr=%0d want no write", mem_addr);
            end else begin
                exp_w = exp_q.pop_front();
                if (mem_addr !== exp_w.addr || mem_wdata !== exp_w.data) begin
                    bad++;
                    $display("[TB] FAIL write_col got addr=%0d data=%h want addr=%0d data=%h",
                             mem_addr, mem_wdata, exp_w.addr, exp_w.data);
                end
            end
        end
    end

    function automatic logic [511:0] rd_ram(input int c);
        return wvalid[c] ? ram[c] : '1;
    endfunction

    task automatic push_crater(input int x, input int y, input int rad, input int maxcols);
        int n, dx, rem, h, lo, hi;
        logic [511:0] w;
        wr_t e;
        n = 0;
        for (int c = x - rad; c <= x + rad; c++) begin
            if (c < 0 || c >= 640 || n >= maxcols) continue;
            dx = c - x;
            rem = rad * rad - dx * dx;
            h = 0;
            while ((h + 1) * (h + 1) <= rem) h++;
            w = exp_ram[c];
            if (y < 512) begin
                lo = (y - h < 0) ? 0 : y - h;
                hi = (y + h > 511) ? 511 : y + h;
                for (int b = lo; b <= hi; b++) w[b] = 1'b0;
            end
            exp_ram[c] = w;
            e.addr = 10'(c);
            e.data = w;
            exp_q.push_back(e);
            n++;
        end
    endtask

    task automatic set_req(input bit i, input int x, input int y, input int rad);
        crx[i] = x;
        cry[i] = y;
        crr[i] = rad;
        if (i == 1'b0) begin
            req_x[9:0] = 10'(x);
            req_y[9:0] = 10'(y);
            req_r[5:0] = 6'(rad);
        end else begin
            req_x[19:10] = 10'(x);
            req_y[19:10] = 10'(y);
            req_r[11:6]  = 6'(rad);
        end
    endtask

    task automatic wait_ack(output logic [1:0] got);
        got = 2'b00;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ack !== 2'b00) begin
                got = ack;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit fin);
        fin = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                fin = 1'b1;
                break;
            end
        end
    endtask

    task automatic serve(output logic [1:0] got, output bit fin);
        bit idx;
        fin = 1'b0;
        wait_ack(got);
        if (got == 2'b00) return;
        idx = got[1];
        push_crater(crx[idx], cry[idx], crr[idx], 1000);
        @(posedge clk); #1;
        req[idx] = 1'b0;
        wait_done(fin);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        set_req(1'b0, 10, 10, 1);
        req = 2'b01;
        repeat (2) @(negedge clk);
        total++; if (ack !== 2'b00)   begin bad++; $display("[TB] FAIL reset_ack got=%b want=00", ack); end
        total++; if (busy !== 1'b0)   begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)   begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_we got=%b want=0", mem_we); end
        total++; if (mem_wdata !== '0) begin bad++; $display("[TB] FAIL reset_wdata got=%h want=0", mem_wdata); end
        total++; if (mem_addr !== disp_addr) begin bad++; $display("[TB] FAIL reset_addr got=%0d want=%0d", mem_addr, disp_addr); end
        req = 2'b00;
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic test_single_crater();
        logic [1:0] got;
        bit fin;
        int d0;
        logic [511:0] want;
        d0 = done_cnt;
        set_req(1'b0, 100, 200, 2);
        @(posedge clk); #1 req = 2'b01;
        serve(got, fin);
        total++; if (got !== 2'b01) begin bad++; $display("[TB] FAIL single_ack got=%b want=01", got); end
        total++; if (!fin) begin bad++; $display("[TB] FAIL single_done got=timeout want=pulse"); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy got=%b want=0", busy); end
        repeat (4) @(negedge clk);
        total++; if (done_cnt - d0 != 1) begin bad++; $display("[TB] FAIL single_done_count got=%0d want=1", done_cnt - d0); end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL single_writes_left got=%0d want=0", exp_q.size()); end
        want = '1; want[202:198] = 5'b0;
        total++; if (rd_ram(100) !== want) begin bad++; $display("[TB] FAIL single_col100 got=%h want=%h", rd_ram(100), want); end
        want = '1; want[200] = 1'b0;
        total++; if (rd_ram(98) !== want) begin bad++; $display("[TB] FAIL single_col98 got=%h want=%h", rd_ram(98), want); end
    endtask

    task automatic test_round_robin();
        logic [1:0] got;
        bit fin;
        do_reset();
        set_req(1'b0, 200, 600, 1);
        set_req(1'b1, 250, 50, 1);
        req = 2'b11;
        serve(got, fin);
        total++; if (got !== 2'b01 || !fin) begin bad++; $display("[TB] FAIL rr_pair1_first got=%b fin=%0d want=01 fin=1", got, fin); end
        serve(got, fin);
        total++; if (got !== 2'b10 || !fin) begin bad++; $display("[TB] FAIL rr_held_second got=%b fin=%0d want=10 fin=1", got, fin); end
        set_req(1'b0, 260, 60, 0);
        @(posedge clk); #1 req = 2'b01;
        serve(got, fin);
        total++; if (got !== 2'b01 || !fin) begin bad++; $display("[TB] FAIL rr_single got=%b fin=%0d want=01 fin=1", got, fin); end
        set_req(1'b0, 270, 70, 0);
        set_req(1'b1, 280, 80, 0);
        @(posedge clk); #1 req = 2'b11;
        serve(got, fin);
        total++; if (got !== 2'b10 || !fin) begin bad++; $display("[TB] FAIL rr_pair2_first got=%b fin=%0d want=10 fin=1", got, fin); end
        serve(got, fin);
        total++; if (got !== 2'b01 || !fin) begin bad++; $display("[TB] FAIL rr_pair2_second got=%b fin=%0d want=01 fin=1", got, fin); end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL rr_writes_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_edge_clip();
        logic [1:0] got;
        bit fin;
        logic [511:0] want;
        set_req(1'b0, 1, 3, 4);
        @(posedge clk); #1 req = 2'b01;
        serve(got, fin);
        total++; if (got !== 2'b01 || !fin) begin bad++; $display("[TB] FAIL clip_handshake got=%b fin=%0d want=01 fin=1", got, fin); end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL clip_writes_left got=%0d want=0", exp_q.size()); end
        want = '1; want[7:0] = 8'h00;
        total++; if (rd_ram(1) !== want) begin bad++; $display("[TB] FAIL clip_col1 got=%h want=%h", rd_ram(1), want); end
    endtask

    task automatic test_vblank_abort();
        logic [1:0] got;
        bit fin, seen;
        int wr_cnt;
        set_req(1'b0, 300, 100, 2);
        @(posedge clk); #1 req = 2'b01;
        wait_ack(got);
        total++; if (got !== 2'b01) begin bad++; $display("[TB] FAIL abort_ack got=%b want=01", got); end
        push_crater(300, 100, 2, 1000);
        @(posedge clk); #1 req = 2'b00;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (mem_addr === 10'd298) begin seen = 1'b1; break; end
        end
        total++; if (!seen) begin bad++; $display("[TB] FAIL abort_rd_seen got=timeout want=addr 298"); end
        @(posedge clk); #1 vblank = 1'b0;
        #1;
        total++; if (mem_addr !== disp_addr) begin bad++; $display("[TB] FAIL abort_addr got=%0d want=%0d", mem_addr, disp_addr); end
        wr_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_we !== 1'b0) wr_cnt++;
        end
        total++; if (wr_cnt != 0) begin bad++; $display("[TB] FAIL abort_no_write got=%0d want=0", wr_cnt); end
        @(posedge clk); #1 vblank = 1'b1;
        wait_done(fin);
        total++; if (!fin) begin bad++; $display("[TB] FAIL abort_done got=timeout want=pulse"); end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL abort_writes_left got=%0d want=0", exp_q.size()); end
        for (int c = 298; c <= 302; c++) begin
            total++;
            if (rd_ram(c) !== exp_ram[c]) begin bad++; $display("[TB] FAIL abort_final_col%0d got=%h want=%h", c, rd_ram(c), exp_ram[c]); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [1:0] got;
        bit seen;
        int d0;
        set_req(1'b0, 400, 50, 2);
        @(posedge clk); #1 req = 2'b01;
        wait_ack(got);
        total++; if (got !== 2'b01) begin bad++; $display("[TB] FAIL rst_ack got=%b want=01", got); end
        push_crater(400, 50, 2, 2);
        d0 = done_cnt;
        @(posedge clk); #1 req = 2'b00;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (mem_addr === 10'd400) begin seen = 1'b1; break; end
        end
        total++; if (!seen) begin bad++; $display("[TB] FAIL rst_rd_seen got=timeout want=addr 400"); end
        @(posedge clk);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL rst_we got=%b want=0", mem_we); end
        total++; if (busy !== 1'b0)   begin bad++; $display("[TB] FAIL rst_busy got=%b want=0", busy); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (done_cnt != d0) begin bad++; $display("[TB] FAIL rst_no_done got=%0d want=0", done_cnt - d0); end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL rst_writes_left got=%0d want=0", exp_q.size()); end
        for (int c = 398; c <= 402; c++) begin
            total++;
            if (rd_ram(c) !== exp_ram[c]) begin bad++; $display("[TB] FAIL rst_col%0d got=%h want=%h", c, rd_ram(c), exp_ram[c]); end
        end
    endtask

    task automatic test_radius_zero_corner();
        logic [1:0] got;
        int t_we, t_done;
        logic [511:0] want;
        set_req(1'b0, 639, 511, 0);
        @(posedge clk); #1 req = 2'b01;
        wait_ack(got);
        total++; if (got !== 2'b01) begin bad++; $display("[TB] FAIL r0_ack got=%b want=01", got); end
        push_crater(639, 511, 0, 1000);
        @(posedge clk); #1 req = 2'b00;
        t_we = -1;
        t_done = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (mem_we === 1'b1) t_we = n;
            if (done === 1'b1) begin t_done = n; break; end
        end
        total++;
        if (t_we < 0 || t_done != t_we + 1) begin
            bad++; $display("[TB] FAIL r0_done_timing got we=%0d done=%0d want done=we+1", t_we, t_done);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL r0_writes_left got=%0d want=0", exp_q.size()); end
        want = '1; want[511] = 1'b0;
        total++; if (rd_ram(639) !== want) begin bad++; $display("[TB] FAIL r0_col639 got=%h want=%h", rd_ram(639), want); end
    endtask

    initial begin
        for (int c = 0; c < 640; c++) exp_ram[c] = '1;
        reset_n   = 1'b0;
        req       = 2'b00;
        req_x     = '0;
        req_y     = '0;
        req_r     = '0;
        vblank    = 1'b1;
        disp_addr = 10'd777;
        test_reset();
        test_single_crater();
        test_round_robin();
        test_edge_clip();
        test_vblank_abort();
        test_reset_mid_sweep();
        test_radius_zero_corner();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
